// File: rtl/eq_band_mixer.sv
// eq_band_mixer
//   Per-band gain and summing stage for the equalizer datapath. One sample per
//   band is captured together with its enable bit and the active gains. A
//   single time-multiplexed multiply-accumulate unit then steps through the
//   bands one per cycle. The sum is rounded half-up and reduced to OUT_W bits.
//   Gains are double-buffered: gain_load writes a shadow register, and the
//   shadow is copied to the active set only when a vector is accepted.
//
// Optional feature macro: EQ_MIX_SAT_EN
//   defined   -> the rounded result saturates to the OUT_W signed range, and
//                sat_flag reports clipping
//   undefined -> the low OUT_W bits are kept (wrap), and sat_flag is 0
//   OUT_W + FRAC_W must not exceed the accumulator width.
//
// Ports
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   in_valid     : band vector valid
//   in_ready     : block idle and able to accept a vector
//   band_in      : N_BANDS signed samples, band k at [k*DATA_W +: DATA_W]
//   band_en      : per-band enable, captured with band_in
//   gain_in      : N_BANDS unsigned gains (value / 2^FRAC_W)
//   gain_load    : load gain_in into the shadow gain register
//   out_valid    : mix_out / sat_flag valid
//   out_ready    : downstream accepts mix_out
//   mix_out      : signed mixed sample
//   sat_flag     : mix_out was clipped (qualified by out_valid)
module eq_band_mixer #(
    parameter int N_BANDS = 8,
    parameter int DATA_W  = 16,
    parameter int GAIN_W  = 4,
    parameter int FRAC_W  = 2,
    parameter int OUT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_BANDS*DATA_W-1:0]   band_in,
    input  logic [N_BANDS-1:0]          band_en,
    input  logic [N_BANDS*GAIN_W-1:0]   gain_in,
    input  logic                        gain_load,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            mix_out,
    output logic                        sat_flag
);

    localparam int IDX_W  = $clog2(N_BANDS);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic [GAIN_W-1:0] UNITY      = GAIN_W'(2 ** FRAC_W);
    // Half an LSB of the output; evaluates to 0 when there are no fraction bits.
    localparam logic [ACC_W-1:0]  ROUND_HALF = ACC_W'((2 ** FRAC_W) / 2);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        OUTPUT
    } state_t;

    state_t state;
    state_t next_state;

    logic [N_BANDS-1:0][DATA_W-1:0] samples;
    logic [N_BANDS-1:0]             enables;
    logic [N_BANDS-1:0][GAIN_W-1:0] shadow_gain;
    logic [N_BANDS-1:0][GAIN_W-1:0] active_gain;
    logic signed [ACC_W-1:0]        acc;
    logic [IDX_W-1:0]               idx;

    logic [DATA_W-1:0]              cur_sample;
    logic [GAIN_W-1:0]              cur_gain;
    logic signed [PROD_W-1:0]       samp_ext;
    logic signed [PROD_W-1:0]       gain_ext;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        term;
    logic                           last_step;

    logic [OUT_W-1:0]               res;
    logic                           clip;

    // ---------------- MAC datapath ----------------
    always_comb begin
        cur_sample = samples[idx];
        cur_gain   = active_gain[idx];
        samp_ext   = {{(GAIN_W + 1){cur_sample[DATA_W-1]}}, cur_sample};
        gain_ext   = {{(DATA_W + 1){1'b0}}, cur_gain};
        // The true product always fits PROD_W bits, so truncation is exact.
        prod       = samp_ext * gain_ext;
        term       = enables[idx] ? {{IDX_W{prod[PROD_W-1]}}, prod} : '0;
        last_step  = (idx == IDX_W'(N_BANDS - 1));
    end

    // ---------------- rounding and output reduction ----------------
`ifdef EQ_MIX_SAT_EN
    logic signed [ACC_W-1:0]   rounded;
    logic signed [ACC_W-1:0]   shifted;
    logic [ACC_W-OUT_W:0]      upper;

    always_comb begin
        rounded = acc + ROUND_HALF;
        shifted = rounded >>> FRAC_W;
        // In range only when every bit from the output sign bit upward matches.
        upper   = shifted[ACC_W-1:OUT_W-1];
        clip    = 1'b0;
        if (!shifted[ACC_W-1] && (|upper)) begin
            res  = {1'b0, {(OUT_W - 1){1'b1}}};
            clip = 1'b1;
        end else if (shifted[ACC_W-1] && !(&upper)) begin
            res  = {1'b1, {(OUT_W - 1){1'b0}}};
            clip = 1'b1;
        end else begin
            res  = shifted[OUT_W-1:0];
        end
    end
`else
    always_comb begin
        // The shift's fill bits lie above the kept window, so a logical shift suffices.
        res  = OUT_W'((acc + ROUND_HALF) >> FRAC_W);
        clip = 1'b0;
    end
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ACCUM;
            end
            ACCUM: begin
                if (last_step) next_state = ROUND;
            end
            ROUND: begin
                next_state = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples     <= '0;
            enables     <= '0;
            shadow_gain <= {N_BANDS{UNITY}};
            active_gain <= {N_BANDS{UNITY}};
            acc         <= '0;
            idx         <= '0;
            out_valid   <= 1'b0;
            mix_out     <= '0;
            sat_flag    <= 1'b0;
        end else begin
            if (gain_load) shadow_gain <= gain_in;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        samples     <= band_in;
                        enables     <= band_en;
                        // A load on the accept edge bypasses the shadow.
                        active_gain <= gain_load ? gain_in : shadow_gain;
                        acc         <= '0;
                        idx         <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + IDX_W'(1);
                end
                ROUND: begin
                    mix_out   <= res;
                    sat_flag  <= clip;
                    out_valid <= 1'b1;
                end
                OUTPUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer
//   Self-checking bench for eq_band_mixer at default parameters. Expected
//   results are pushed to a queue when a vector is sent and popped when the
//   DUT presents out_valid. Expectations follow EQ_MIX_SAT_EN when defined.
module tb_eq_band_mixer;

    localparam int N = 8;
    localparam int D = 16;
    localparam int G = 4;
    localparam int F = 2;
    localparam int O = 16;

    typedef struct packed {
        logic [O-1:0] mix;
        logic         sat;
    } exp_t;

`ifdef EQ_MIX_SAT_EN
    localparam logic [O-1:0] POS_FULL_MIX = 16'h7FFF;
    localparam logic         POS_FULL_SAT = 1'b1;
    localparam logic [O-1:0] NEG_FULL_MIX = 16'h8000;
    localparam logic         NEG_FULL_SAT = 1'b1;
`else
    localparam logic [O-1:0] POS_FULL_MIX = 16'hFFE2;  // -30
    localparam logic         POS_FULL_SAT = 1'b0;
    localparam logic [O-1:0] NEG_FULL_MIX = 16'h0000;
    localparam logic         NEG_FULL_SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*D-1:0]   band_in;
    logic [N-1:0]     band_en;
    logic [N*G-1:0]   gain_in;
    logic             gain_load;
    logic             out_valid;
    logic             out_ready;
    logic [O-1:0]     mix_out;
    logic             sat_flag;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];
    logic [N*G-1:0] tb_gain;

    eq_band_mixer #(
        .N_BANDS(N),
        .DATA_W (D),
        .GAIN_W (G),
        .FRAC_W (F),
        .OUT_W  (O)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .band_in  (band_in),
        .band_en  (band_en),
        .gain_in  (gain_in),
        .gain_load(gain_load),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mix_out  (mix_out),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [N*D-1:0] all_bands(input int v);
        logic [N*D-1:0] r;
        for (int k = 0; k < N; k++) r[k*D +: D] = v[D-1:0];
        return r;
    endfunction

    function automatic logic [N*G-1:0] all_gains(input int v);
        logic [N*G-1:0] r;
        for (int k = 0; k < N; k++) r[k*G +: G] = v[G-1:0];
        return r;
    endfunction

    // Reference: exact integer sum, round half up, then saturate or wrap.
    function automatic exp_t model(input logic [N*D-1:0] b, input logic [N-1:0] en,
                                   input logic [N*G-1:0] g);
        longint sum = 0;
        longint r;
        exp_t   e;
        for (int k = 0; k < N; k++)
            if (en[k]) sum += longint'($signed(b[k*D +: D])) * longint'({1'b0, g[k*G +: G]});
        r = (sum + (longint'(1) << (F - 1))) >>> F;
`ifdef EQ_MIX_SAT_EN
        if (r > 32767) begin
            e.mix = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.mix = 16'h8000; e.sat = 1'b1;
        end else begin
            e.mix = r[O-1:0]; e.sat = 1'b0;
        end
`else
        e.mix = r[O-1:0];
        e.sat = 1'b0;
`endif
        return e;
    endfunction

    task automatic load_gains(input logic [N*G-1:0] g);
        @(negedge clk);
        gain_in   = g;
        gain_load = 1'b1;
        @(posedge clk);
        #1;
        gain_load = 1'b0;
        tb_gain   = g;
    endtask

    // Sends one vector; pushes either the model result or the given constant.
    task automatic send(input logic [N*D-1:0] b, input logic [N-1:0] en,
                        input bit with_load, input logic [N*G-1:0] g,
                        input bit use_model, input logic [O-1:0] exp_mix, input logic exp_sat);
        int   cyc = 0;
        exp_t e;
        @(negedge clk);
        band_in  = b;
        band_en  = en;
        in_valid = 1'b1;
        if (with_load) begin
            gain_in   = g;
            gain_load = 1'b1;
        end
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 100) begin
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, cyc);
        end
        if (with_load) tb_gain = g;
        if (use_model) e = model(b, en, tb_gain);
        else begin
            e.mix = exp_mix;
            e.sat = exp_sat;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        gain_load = 1'b0;
    endtask

    // Waits for out_valid, compares against the scoreboard, then handshakes.
    task automatic collect(input string name, input int exp_lat);
        int   cyc = 0;
        exp_t e;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_out_timeout: out_valid=%b after %0d cycles, required 1", name, out_valid, cyc);
            return;
        end
        if (exp_lat >= 0) begin
            checks++;
            if (cyc !== exp_lat) begin
                fails++;
                $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, exp_lat);
            end
        end
        checks++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_unexpected_output: mix_out=%0d, no expectation queued", name, $signed(mix_out));
        end else begin
            e = sb.pop_front();
            if (mix_out !== e.mix || sat_flag !== e.sat) begin
                fails++;
                $display("FAIL %s_result: mix_out=%0d sat_flag=%b, required mix_out=%0d sat_flag=%b",
                         name, $signed(mix_out), sat_flag, $signed(e.mix), e.sat);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_return_idle: out_valid=%b in_ready=%b, required 0 and 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        gain_load = 1'b0;
        out_ready = 1'b0;
        band_in   = '0;
        band_en   = '0;
        gain_in   = '0;
        tb_gain   = all_gains(4);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || mix_out !== '0 || sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b mix_out=%0d sat_flag=%b, required 0 0 0",
                     out_valid, $signed(mix_out), sat_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_unity();
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd8000, 1'b0);
        collect("unity", N + 1);
    endtask

    task automatic test_saturation();
        load_gains(all_gains(15));
        send(all_bands(32767), 8'hFF, 1'b0, '0, 1'b0, POS_FULL_MIX, POS_FULL_SAT);
        collect("pos_full", -1);
        send(all_bands(-32768), 8'hFF, 1'b0, '0, 1'b0, NEG_FULL_MIX, NEG_FULL_SAT);
        collect("neg_full", -1);
    endtask

    task automatic test_rounding();
        logic [N*G-1:0] g;
        logic [N*D-1:0] b;
        g = all_gains(15);
        g[G-1:0] = 4'd1;
        b = all_bands(32767);
        b[D-1:0] = 16'hFFFD;  // -3
        load_gains(g);
        send(b, 8'b0000_0001, 1'b0, '0, 1'b0, 16'hFFFF, 1'b0);
        collect("rounding", -1);
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        load_gains(all_gains(4));
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd8000, 1'b0);
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            band_in  = all_bands(5);
            in_valid = (i == 2);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || mix_out !== 16'd8000 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold_%0d: out_valid=%b mix_out=%0d in_ready=%b, required 1 8000 0",
                         i, out_valid, $signed(mix_out), in_ready);
            end
        end
        in_valid = 1'b0;
        collect("backpressure", -1);
        // The in_valid pulse during OUTPUT must not have started a new sample.
        cyc = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) cyc++;
        end
        checks++;
        if (cyc != 0) begin
            fails++;
            $display("FAIL backpressure_ignored_in: %0d non-idle cycles, required 0", cyc);
        end
    endtask

    task automatic test_gain_shadow();
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd8000, 1'b0);
        repeat (3) @(posedge clk);
        load_gains(all_gains(8));
        collect("shadow_in_flight", -1);
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd16000, 1'b0);
        collect("shadow_next", -1);
        // Load on the accept edge applies to that same vector.
        send(all_bands(1000), 8'hFF, 1'b1, all_gains(12), 1'b0, 16'd24000, 1'b0);
        collect("shadow_same_edge", -1);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd8000, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_abort: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        sb.delete();
        tb_gain = all_gains(4);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL reset_mid_no_output: %0d cycles with out_valid=1, required 0", bad);
        end
        send(all_bands(1000), 8'hFF, 1'b0, '0, 1'b0, 16'd8000, 1'b0);
        collect("reset_mid_after", N + 1);
    endtask

    task automatic test_back_to_back();
        logic [N*D-1:0] b;
        logic [N*G-1:0] g;
        logic [N-1:0]   en;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) begin
                b[k*D +: D] = D'($urandom);
                g[k*G +: G] = G'($urandom);
            end
            en = N'($urandom);
            if (i % 3 == 1) load_gains(g);
            send(b, en, (i % 3 == 2), g, 1'b1, '0, 1'b0);
            collect("back_to_back", N + 1);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_rounding();
        test_backpressure();
        test_gain_shadow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
